// File: rtl/uart_word_packer_if.sv
// Byte-in / word-out bus of the UART word packer: UART RX strobe side plus FIFO write side.
// The packer takes the slave modport; whatever drives bytes and models the FIFO takes master.
interface uart_word_packer_if #(
    parameter int DATA_WIDTH = 256
) ();
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  flush;
    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_wdata;

    modport master (
        output rx_data, rx_valid, flush, fifo_full,
        input  fifo_wr_en, fifo_wdata
    );

    modport slave (
        input  rx_data, rx_valid, flush, fifo_full,
        output fifo_wr_en, fifo_wdata
    );
endinterface

// File: rtl/uart_word_packer.sv
// Packs UART RX bytes (first byte in lane 0) into DATA_WIDTH-bit words for the async word FIFO.
// Two buffer levels: an accumulator plus a holding register that feeds the FIFO write port.
module uart_word_packer #(
    parameter int         DATA_WIDTH = 256,
    parameter logic [7:0] PAD_BYTE   = 8'h00
) (
    input  logic                uart_clk,
    input  logic                rst,
    uart_word_packer_if.slave   bus,
    output logic                overflow,
    output logic [31:0]         word_count,
    output logic                busy
);
    localparam int            BPW      = DATA_WIDTH / 8;
    localparam int            CW       = $clog2(BPW) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(BPW);

    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]         accCnt_q, accCnt_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  holdValid_q, holdValid_d;
    logic                  overflow_q, overflow_d;
    logic [31:0]           wordCount_q, wordCount_d;

    logic                  wrEn, holdFree, stalled, doFlush, complete;
    logic [CW-1:0]         cntAfter;
    logic [DATA_WIDTH-1:0] merged, padded, completedWord;

    assign wrEn     = holdValid_q & ~bus.fifo_full;
    assign holdFree = ~holdValid_q | wrEn;
    assign stalled  = (accCnt_q == FULL_CNT);

    // A stalled accumulator takes no byte into its own lanes; a byte arriving as it drains starts the next word.
    always_comb begin
        merged   = acc_q;
        cntAfter = accCnt_q;
        if (!stalled && bus.rx_valid) begin
            for (int i = 0; i < BPW; i++) begin
                if (CW'(i) == accCnt_q) merged[8*i +: 8] = bus.rx_data;
            end
            cntAfter = accCnt_q + 1'b1;
        end
        padded = merged;
        for (int i = 0; i < BPW; i++) begin
            if (CW'(i) >= cntAfter) padded[8*i +: 8] = PAD_BYTE;
        end
        doFlush       = bus.flush && !stalled && (cntAfter != '0) && (cntAfter != FULL_CNT);
        complete      = stalled || (cntAfter == FULL_CNT) || doFlush;
        completedWord = doFlush ? padded : merged;
    end

    always_comb begin
        acc_d       = acc_q;
        accCnt_d    = accCnt_q;
        hold_d      = hold_q;
        holdValid_d = holdValid_q & ~wrEn;
        overflow_d  = overflow_q;
        wordCount_d = wordCount_q + 32'(wrEn);
        if (complete && holdFree) begin
            hold_d      = completedWord;
            holdValid_d = 1'b1;
            if (stalled && bus.rx_valid) begin
                acc_d    = {{(DATA_WIDTH-8){1'b0}}, bus.rx_data};
                accCnt_d = CW'(1);
            end else begin
                acc_d    = '0;
                accCnt_d = '0;
            end
        end else if (complete) begin
            acc_d      = completedWord;
            accCnt_d   = FULL_CNT;
            overflow_d = overflow_q | (stalled & bus.rx_valid);
        end else begin
            acc_d    = merged;
            accCnt_d = cntAfter;
        end
    end

    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            accCnt_q    <= '0;
            hold_q      <= '0;
            holdValid_q <= 1'b0;
            overflow_q  <= 1'b0;
            wordCount_q <= '0;
        end else begin
            acc_q       <= acc_d;
            accCnt_q    <= accCnt_d;
            hold_q      <= hold_d;
            holdValid_q <= holdValid_d;
            overflow_q  <= overflow_d;
            wordCount_q <= wordCount_d;
        end
    end

    assign bus.fifo_wr_en = wrEn;
    assign bus.fifo_wdata = hold_q;
    assign overflow       = overflow_q;
    assign word_count     = wordCount_q;
    assign busy           = (accCnt_q != '0) | holdValid_q;
endmodule
